// File: rtl/jtag_scan_sequencer.sv
`default_nettype none
// ============================================================================
// jtag_scan_sequencer : host-side JTAG master issuing one IR and/or DR scan per
//                       command and returning the captured TDO bits.
// Revision 1.0
// ============================================================================
module jtag_scan_sequencer #(
  parameter int IR_LEN = 2,
  parameter int DR_MAX = 128,
  parameter int CNT_W  = 8
) (
  input  logic              TCLK,
  input  logic              TRST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_skip_ir,
  input  logic [IR_LEN-1:0] cmd_ir,
  input  logic [CNT_W-1:0]  cmd_dr_len,
  input  logic [DR_MAX-1:0] cmd_dr_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DR_MAX-1:0] rsp_data,
  output logic [IR_LEN-1:0] rsp_ir_cap,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo,
  output logic              busy
);

  localparam int DR_IW = (DR_MAX > 1) ? $clog2(DR_MAX) : 1;
  localparam int IR_IW = (IR_LEN > 1) ? $clog2(IR_LEN) : 1;
  localparam logic [CNT_W-1:0] C_IR_LAST  = CNT_W'(IR_LEN - 1);
  localparam logic [CNT_W-1:0] C_DR_MAX   = CNT_W'(DR_MAX);
  localparam logic [CNT_W-1:0] C_TLR_LAST = CNT_W'(4);
  localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);

  typedef enum logic [3:0] {
    TLR, GO_RTI, IDLE,
    IR_SEL, IR_CAP, IR_SHIFT, IR_BITS, IR_UPD, IR_RTI,
    DR_SEL, DR_CAP, DR_SHIFT, DR_BITS, DR_UPD, DR_RTI,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IR_LEN-1:0]   ir_q, ir_d;
  logic [CNT_W-1:0]    dr_len_q, dr_len_d;
  logic [DR_MAX-1:0]   dr_data_q, dr_data_d;
  logic                tms_q, tms_d;
  logic                tdi_q, tdi_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DR_MAX-1:0]   rsp_data_q, rsp_data_d;
  logic [IR_LEN-1:0]   rsp_ir_cap_q, rsp_ir_cap_d;
  logic                busy_q, busy_d;

  always_ff @(posedge TCLK) begin
    if (!TRST) begin
      state_q      <= TLR;
      cnt_q        <= '0;
      ir_q         <= '0;
      dr_len_q     <= '0;
      dr_data_q    <= '0;
      tms_q        <= 1'b1;
      tdi_q        <= 1'b0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_ir_cap_q <= '0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ir_q         <= ir_d;
      dr_len_q     <= dr_len_d;
      dr_data_q    <= dr_data_d;
      tms_q        <= tms_d;
      tdi_q        <= tdi_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_ir_cap_q <= rsp_ir_cap_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ir_d         = ir_q;
    dr_len_d     = dr_len_q;
    dr_data_d    = dr_data_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_ir_cap_d = rsp_ir_cap_q;

    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    unique case (state_q)
      TLR: begin
        if (cnt_q == C_TLR_LAST) begin
          state_d = GO_RTI;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      GO_RTI: state_d = IDLE;
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          dr_len_d     = (cmd_dr_len > C_DR_MAX) ? C_DR_MAX : cmd_dr_len;
          dr_data_d    = cmd_dr_data;
          rsp_data_d   = '0;
          rsp_ir_cap_d = '0;
          cnt_d        = '0;
          if (!cmd_skip_ir) begin
            ir_d    = cmd_ir;
            state_d = IR_SEL;
          end else if (cmd_dr_len != '0) begin
            state_d = DR_SEL;
          end else begin
            state_d = DONE;
          end
        end
      end
      // Two TMS=1 cycles walk Run-Test/Idle -> Select-DR -> Select-IR.
      IR_SEL: begin
        if (cnt_q == C_ONE) begin
          state_d = IR_CAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      IR_CAP:   state_d = IR_SHIFT;
      IR_SHIFT: begin
        state_d = IR_BITS;
        cnt_d   = '0;
      end
      IR_BITS: begin
        rsp_ir_cap_d[cnt_q[IR_IW-1:0]] = tdo;
        if (cnt_q == C_IR_LAST) state_d = IR_UPD;
        else                    cnt_d   = cnt_q + C_ONE;
      end
      IR_UPD: state_d = IR_RTI;
      IR_RTI: state_d = (dr_len_q != '0) ? DR_SEL : DONE;
      DR_SEL: state_d = DR_CAP;
      DR_CAP: state_d = DR_SHIFT;
      DR_SHIFT: begin
        state_d = DR_BITS;
        cnt_d   = '0;
      end
      DR_BITS: begin
        rsp_data_d[cnt_q[DR_IW-1:0]] = tdo;
        if (cnt_q == dr_len_q - C_ONE) state_d = DR_UPD;
        else                           cnt_d   = cnt_q + C_ONE;
      end
      DR_UPD: state_d = DR_RTI;
      DR_RTI: state_d = DONE;
      DONE: begin
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = TLR;
    endcase

    // Pin values are registered from the next state so they line up with the
    // cycle the FSM spends in that state.
    tms_d = 1'b0;
    tdi_d = 1'b0;
    unique case (state_d)
      TLR, IR_SEL, IR_UPD, DR_SEL, DR_UPD: tms_d = 1'b1;
      IR_BITS: begin
        tms_d = (cnt_d == C_IR_LAST);
        tdi_d = ir_d[cnt_d[IR_IW-1:0]];
      end
      DR_BITS: begin
        tms_d = (cnt_d == dr_len_d - C_ONE);
        tdi_d = dr_data_d[cnt_d[DR_IW-1:0]];
      end
      default: tms_d = 1'b0;
    endcase

    cmd_ready_d = (state_d == IDLE) && !rsp_valid_d;
    busy_d      = (state_d != IDLE);
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_ir_cap = rsp_ir_cap_q;
  assign tms        = tms_q;
  assign tdi        = tdi_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_scan_sequencer.sv
`default_nettype none
// ============================================================================
// tb_jtag_scan_sequencer : randomized command bench with a scan-sequence
//                          reference model built from the TAP walk rules.
// Revision 1.0
// ============================================================================
module tb_jtag_scan_sequencer;

  localparam int IR_LEN = 2;
  localparam int DR_MAX = 128;
  localparam int CNT_W  = 8;

  logic              TCLK;
  logic              TRST;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_skip_ir;
  logic [IR_LEN-1:0] cmd_ir;
  logic [CNT_W-1:0]  cmd_dr_len;
  logic [DR_MAX-1:0] cmd_dr_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DR_MAX-1:0] rsp_data;
  logic [IR_LEN-1:0] rsp_ir_cap;
  logic              tms;
  logic              tdi;
  logic              tdo;
  logic              busy;

  jtag_scan_sequencer #(.IR_LEN(IR_LEN), .DR_MAX(DR_MAX), .CNT_W(CNT_W)) dut (
    .TCLK(TCLK), .TRST(TRST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_skip_ir(cmd_skip_ir),
    .cmd_ir(cmd_ir), .cmd_dr_len(cmd_dr_len), .cmd_dr_data(cmd_dr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_ir_cap(rsp_ir_cap), .tms(tms), .tdi(tdi), .tdo(tdo), .busy(busy)
  );

  initial TCLK = 1'b0;
  always #5 TCLK = ~TCLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [DR_MAX-1:0] got, input logic [DR_MAX-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge TCLK);
    #1;
  endtask

  // Expected per-cycle pin stream; kind 1 = IR shift bit, 2 = DR shift bit.
  bit q_tms[$];
  bit q_tdi[$];
  int q_kind[$];
  int q_idx[$];

  task automatic push(input bit t, input bit d, input int k, input int x);
    q_tms.push_back(t); q_tdi.push_back(d); q_kind.push_back(k); q_idx.push_back(x);
  endtask

  task automatic build_seq(input bit skip, input logic [IR_LEN-1:0] ir, input int len,
                           input logic [DR_MAX-1:0] data);
    q_tms.delete(); q_tdi.delete(); q_kind.delete(); q_idx.delete();
    if (!skip) begin
      push(1, 0, 0, 0); push(1, 0, 0, 0); push(0, 0, 0, 0); push(0, 0, 0, 0);
      for (int k = 0; k < IR_LEN; k++) push(k == IR_LEN - 1, ir[k], 1, k);
      push(1, 0, 0, 0); push(0, 0, 0, 0);
    end
    if (len > 0) begin
      push(1, 0, 0, 0); push(0, 0, 0, 0); push(0, 0, 0, 0);
      for (int k = 0; k < len; k++) push(k == len - 1, data[k], 2, k);
      push(1, 0, 0, 0); push(0, 0, 0, 0);
    end
    push(0, 0, 0, 0);
  endtask

  task automatic expect_tlr_replay();
    for (int i = 0; i < 5; i++) begin
      chk("tlr_tms", tms, 1);
      chk("tlr_busy", busy, 1);
      tick();
    end
    chk("go_rti_tms", tms, 0);
    chk("go_rti_busy", busy, 1);
    tick();
    chk("idle_cmd_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_tms", tms, 0);
  endtask

  task automatic do_reset(input int cycles);
    TRST = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      chk("rst_tms", tms, 1);
      chk("rst_tdi", tdi, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 1);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_ir_cap", rsp_ir_cap, 0);
    end
    TRST = 1'b1;
    expect_tlr_replay();
  endtask

  function automatic logic [DR_MAX-1:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // bypass=1 drives tdo as a 1-bit bypass register would (capture 0, then tdi delayed by one).
  task automatic run_cmd(input bit skip, input logic [IR_LEN-1:0] ir, input int len,
                         input logic [DR_MAX-1:0] data, input int hold, input int abort_k,
                         input bit bypass);
    int w;
    int leff;
    bit t;
    logic [DR_MAX-1:0] exp_data;
    logic [IR_LEN-1:0] exp_ir;

    w = 0;
    while (cmd_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    if (cmd_ready !== 1'b1) begin
      chk("cmd_ready_timeout", cmd_ready, 1);
      return;
    end

    leff = (len > DR_MAX) ? DR_MAX : len;
    build_seq(skip, ir, leff, data);
    exp_data = '0;
    exp_ir   = '0;

    cmd_valid   = 1'b1;
    cmd_skip_ir = skip;
    cmd_ir      = ir;
    cmd_dr_len  = len[CNT_W-1:0];
    cmd_dr_data = data;
    tick();
    cmd_valid   = 1'b0;
    cmd_skip_ir = 1'($urandom());
    cmd_ir      = IR_LEN'($urandom());
    cmd_dr_len  = CNT_W'($urandom());
    cmd_dr_data = rnd_data();

    for (int i = 0; i < q_tms.size(); i++) begin
      chk("scan_tms", tms, q_tms[i]);
      chk("scan_tdi", tdi, q_tdi[i]);
      chk("scan_busy", busy, 1);
      chk("scan_rsp_valid", rsp_valid, 0);
      chk("scan_cmd_ready", cmd_ready, 0);
      if (bypass && q_kind[i] == 2) t = (q_idx[i] == 0) ? 1'b0 : data[q_idx[i] - 1];
      else                          t = 1'($urandom());
      tdo = t;
      if (q_kind[i] == 1) exp_ir[q_idx[i]]   = t;
      if (q_kind[i] == 2) exp_data[q_idx[i]] = t;
      if (abort_k >= 0 && q_kind[i] == 2 && q_idx[i] == abort_k) begin
        TRST = 1'b0;
        tick();
        chk("abort_tms", tms, 1);
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_busy", busy, 1);
        TRST = 1'b1;
        expect_tlr_replay();
        return;
      end
      tick();
    end

    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_ir_cap", rsp_ir_cap, exp_ir);
    chk("done_busy", busy, 0);
    chk("done_cmd_ready", cmd_ready, 0);
    chk("done_tms", tms, 0);
    if (bypass) chk("bypass_a5", rsp_data[7:0], 8'h4A);

    cmd_valid   = 1'b1;
    cmd_dr_data = rnd_data();
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_data", rsp_data, exp_data);
      chk("hold_rsp_ir_cap", rsp_ir_cap, exp_ir);
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_busy", busy, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("release_rsp_valid", rsp_valid, 0);
    chk("release_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    TRST        = 1'b0;
    cmd_valid   = 1'b0;
    cmd_skip_ir = 1'b0;
    cmd_ir      = '0;
    cmd_dr_len  = '0;
    cmd_dr_data = '0;
    rsp_ready   = 1'b0;
    tdo         = 1'b0;

    do_reset(3);

    run_cmd(1'b0, 2'b10, 0, '0, 0, -1, 1'b0);
    run_cmd(1'b1, 2'b00, 75, rnd_data(), 2, -1, 1'b0);
    run_cmd(1'b0, 2'b11, 8, DR_MAX'(8'hA5), 0, -1, 1'b1);
    run_cmd(1'b1, 2'b00, 12, rnd_data(), 20, -1, 1'b0);
    run_cmd(1'b1, 2'b00, 40, rnd_data(), 0, 30, 1'b0);
    run_cmd(1'b1, 2'b00, 0, rnd_data(), 1, -1, 1'b0);
    run_cmd(1'b0, 2'b01, 1, rnd_data(), 0, -1, 1'b0);
    run_cmd(1'b1, 2'b00, 200, rnd_data(), 0, -1, 1'b0);
    run_cmd(1'b0, 2'b10, DR_MAX, rnd_data(), 0, -1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      int sel;
      int len;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       len = 0;
        1:       len = 1;
        2:       len = DR_MAX;
        3:       len = $urandom_range(129, 255);
        default: len = $urandom_range(0, 100);
      endcase
      run_cmd(1'($urandom()), IR_LEN'($urandom()), len, rnd_data(),
              $urandom_range(0, 4), -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
